icache_dm: RTL and testbench
============================

Name: icache_dm

Overview:
- Direct-mapped instruction cache between the pipelined core's fetch stage (pcF/instrF) and a slow backing instruction memory.
- On a hit, the instruction is returned combinationally in the same cycle with no stall.
- On a miss, fetch is stalled while a 4-word line is burst-filled over a req/ack handshake.
- Provides a global invalidate and saturating hit/miss counters for performance bring-up.

Parameters:
- IDX_W, 4, index bits; LINES = 2^IDX_W = 16.
- OFF_W, 2, word-offset bits; WORDS = 2^OFF_W = 4 words per line.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  reset, asynchronous, active-high.
- cpu_req  in  1  fetch valid this cycle.
- cpu_addr  in  32  byte address from fetch (pcF); bits [1:0] ignored.
- cpu_instr  out  32  instruction word; 0 when not hitting.
- cpu_stall  out  1  stall fetch/decode; combinational.
- inv  in  1  invalidate all lines (single-cycle pulse).
- mem_req  out  1  backing-memory read request (level).
- mem_addr  out  32  word-aligned backing-memory address.
- mem_ack  in  1  one-cycle pulse; mem_rdata valid this cycle.
- mem_rdata  in  32  backing-memory read data.
- hit_cnt  out  CNT_W  saturating hit count.
- miss_cnt  out  CNT_W  saturating miss count.

Behaviour:
- Address split:
  - woff = addr[OFF_W+1:2]
  - idx = addr[OFF_W+IDX_W+1:OFF_W+2]
  - tag = addr[31:OFF_W+IDX_W+2] (24 bits at defaults)
- Storage:
  - valid[LINES], tag[LINES] and data[LINES][WORDS] held in flops.
  - No reset on data or tag arrays; valid is reset to 0.
- Hit:
  - hit = cpu_req & state==IDLE & valid[idx] & tag[idx]==tag.
  - cpu_instr = data[idx][woff] when hit, else 32'h0.
- Stall:
  - cpu_stall = (cpu_req & ~hit) | state!=IDLE.
  - cpu_req=0 in IDLE gives cpu_stall=0.
- FSM states: IDLE, FILL, DONE.
- IDLE:
  - On cpu_req & ~hit: latch miss tag/idx, clear valid[idx], wcnt<=0, go to FILL, miss_cnt++.
  - Each cycle with hit: hit_cnt++.
- FILL:
  - mem_req=1.
  - mem_addr = {miss_tag, miss_idx, wcnt, 2'b00}, held stable until mem_ack.
  - On mem_ack: data[miss_idx][wcnt]<=mem_rdata, wcnt++.
  - On the ack with wcnt==WORDS-1: go to DONE.
  - mem_req may stay high across consecutive words; mem_addr advances the cycle after each ack.
- DONE:
  - mem_req=0.
  - tag[miss_idx]<=miss_tag; valid[miss_idx]<=1 unless an invalidate is pending.
  - Go to IDLE.
  - The next cycle re-evaluates the current cpu_addr (normally a hit).
- Miss latency: 1 (IDLE->FILL) + 4 ack cycles minimum + 1 DONE. With 1-cycle memory, an address missing in cycle N hits in cycle N+6.
- cpu_addr changing during FILL/DONE is ignored: the fill always completes for the latched line, and stall is held throughout.
- mem_ack while mem_req=0 is ignored.
- mem_rdata is sampled only on mem_ack.
- inv in IDLE: all valid<=0 next edge. If a miss starts that same cycle, the miss proceeds normally.
- inv during FILL or DONE:
  - Sets inv_pend.
  - At DONE, all valid<=0 and the filled line is not marked valid.
  - inv_pend clears on DONE.
- Counters: increment by 1, saturate at all-ones, no wrap. Reset to 0.
- Reset asserted at any time, including mid-fill:
  - Immediately: state=IDLE, mem_req=0, mem_addr=0, valid all 0, wcnt=0, inv_pend=0, counters=0.
  - cpu_instr=0; cpu_stall=cpu_req.
- Outputs are glitch-tolerant combinational from flops and cpu_* inputs only. There is no combinational path from mem_ack to cpu_stall.

Test Plan:
- Cold miss:
  - Stimulus: reset, cpu_req=1, cpu_addr=0x0000_0040, memory acks every cycle with data 0xA0+word.
  - Required: mem_addr sequence 0x40, 0x44, 0x48, 0x4C.
  - Required: cpu_stall high for 6 cycles, then cpu_instr=0xA0, miss_cnt=1.
- Spatial hit:
  - Stimulus: after the cold miss, cpu_addr=0x44, 0x48, 0x4C on successive cycles.
  - Required: cpu_stall=0 and cpu_instr=0xA1, 0xA2, 0xA3; hit_cnt=4.
- Conflict eviction:
  - Stimulus: fetch 0x040, then 0x440 (same idx, different tag), then 0x040.
  - Required: three misses, miss_cnt=3, mem_addr bursts start 0x040, 0x440, 0x040.
- Slow memory / address wobble:
  - Stimulus: mem_ack delayed 3 cycles per word; cpu_addr toggles during FILL.
  - Required: mem_addr held stable until each ack, fill completes for the latched line, stall is continuous.
- Invalidate:
  - Stimulus: inv pulse in IDLE after lines 0x40 and 0x80 are valid.
  - Required: the next fetch of each misses.
  - Stimulus: inv pulse mid-FILL.
  - Required: the filled line is not valid after DONE; refetching it misses.
- Reset mid-fill:
  - Stimulus: assert reset after the 2nd ack.
  - Required: mem_req=0 immediately, counters=0; after release, the same address misses and performs a full 4-word burst from word 0.

Source files
------------

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache between the fetch stage and a slow backing
// instruction memory. A hit returns the word combinationally with no stall.
// A miss stalls fetch while a 4-word line is burst-filled over a req/ack
// handshake. Also provides a global invalidate and saturating hit/miss counters.
module icache_dm #(
  parameter int IDX_W = 4,
  parameter int OFF_W = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic [31:0]      cpu_addr,
  output logic [31:0]      cpu_instr,
  output logic             cpu_stall,
  input  logic             inv,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int LINES = 1 << IDX_W;
  localparam int WORDS = 1 << OFF_W;
  localparam int TAG_W = 32 - IDX_W - OFF_W - 2;

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t           state;
  logic [LINES-1:0] validBits;
  logic [TAG_W-1:0] tagMem  [LINES];
  logic [31:0]      dataMem [LINES][WORDS];

  logic [TAG_W-1:0] missTag;
  logic [IDX_W-1:0] missIdx;
  logic [OFF_W-1:0] wcnt;
  logic [OFF_W-1:0] nextWcnt;
  logic             invPend;
  logic [CNT_W-1:0] hitCount;
  logic [CNT_W-1:0] missCount;

  logic [OFF_W-1:0] reqOff;
  logic [IDX_W-1:0] reqIdx;
  logic [TAG_W-1:0] reqTag;
  logic             hit;
  logic             unusedAddrBits;

  // Fetch address split; the byte-offset bits carry no information.
  assign reqOff         = cpu_addr[OFF_W+1:2];
  assign reqIdx         = cpu_addr[OFF_W+IDX_W+1:OFF_W+2];
  assign reqTag         = cpu_addr[31:OFF_W+IDX_W+2];
  assign unusedAddrBits = ^cpu_addr[1:0];

  // Hits are only served while idle, so a line being filled never looks valid
  // and nothing from the memory side reaches the stall output.
  assign hit       = cpu_req && (state == IDLE) && validBits[reqIdx] && (tagMem[reqIdx] == reqTag);
  assign cpu_instr = hit ? dataMem[reqIdx][reqOff] : 32'h0;
  assign cpu_stall = (cpu_req && !hit) || (state != IDLE);
  assign nextWcnt  = wcnt + OFF_W'(1);
  assign hit_cnt   = hitCount;
  assign miss_cnt  = missCount;

  // Miss/fill sequencer with valid bits, invalidate tracking and counters.
  // NOTE: every register here is assigned with <= so all reads see the
  // pre-edge values; a later assignment in the same cycle wins (used below
  // when an invalidate and a miss arrive together).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      validBits <= '0;
      missTag   <= '0;
      missIdx   <= '0;
      wcnt      <= '0;
      invPend   <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      hitCount  <= '0;
      missCount <= '0;
    end else begin
      if (hit && (hitCount != '1)) hitCount <= hitCount + CNT_W'(1);
      case (state)
        IDLE: begin
          if (inv) validBits <= '0;
          if (cpu_req && !hit) begin
            missTag           <= reqTag;
            missIdx           <= reqIdx;
            wcnt              <= '0;
            validBits[reqIdx] <= 1'b0;
            mem_req           <= 1'b1;
            mem_addr          <= {reqTag, reqIdx, {OFF_W{1'b0}}, 2'b00};
            if (missCount != '1) missCount <= missCount + CNT_W'(1);
            state             <= FILL;
          end
        end
        FILL: begin
          if (inv) invPend <= 1'b1;
          if (mem_ack) begin
            wcnt     <= nextWcnt;
            mem_addr <= {missTag, missIdx, nextWcnt, 2'b00};
            if (wcnt == OFF_W'(WORDS - 1)) begin
              mem_req <= 1'b0;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          // An invalidate seen during the fill (or right now) wins over the
          // freshly filled line.
          if (invPend || inv) validBits <= '0;
          else                validBits[missIdx] <= 1'b1;
          invPend <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line storage: capture each acked word, then the tag when the fill ends.
  // NOTE: the tag and data arrays are deliberately left without reset; the
  // valid bits alone decide whether their contents are ever used.
  always_ff @(posedge clk) begin
    if ((state == FILL) && mem_ack) dataMem[missIdx][wcnt] <= mem_rdata;
    if (state == DONE)              tagMem[missIdx]        <= missTag;
  end

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: a responder plays the backing memory,
// expected fetch words and burst addresses are queued by the stimulus and
// popped by a monitor whenever the cache delivers a hit or sees an ack.
module tb_icache_dm;

  logic        clk;
  logic        reset;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_instr;
  logic        cpu_stall;
  logic        inv;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int nChecks = 0;
  int nPass   = 0;
  int memDelay = 0;

  logic [31:0] instrQ[$];
  logic [31:0] addrQ[$];

  icache_dm dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_instr (cpu_instr),
    .cpu_stall (cpu_stall),
    .inv       (inv),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual === expected) nPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Backing memory: word at byte address A holds (A >> 2) + 0x90, so line
  // 0x40 holds 0xA0..0xA3. Each word is acked after memDelay idle cycles.
  initial begin : memory_model
    int          waitCnt;
    logic [31:0] firstAddr;
    waitCnt   = 0;
    firstAddr = '0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_req) begin
        if (waitCnt == 0) firstAddr = mem_addr;
        if (waitCnt >= memDelay) begin
          mem_ack   = 1'b1;
          mem_rdata = (mem_addr >> 2) + 32'h90;
          if (memDelay > 0) check("mem_addr_stable", mem_addr, firstAddr);
          waitCnt   = 0;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 32'hDEAD_BEEF;
          waitCnt++;
        end
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        waitCnt   = 0;
      end
    end
  end

  // Monitor: pop and compare on every delivered hit and every accepted ack.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!reset && cpu_req && !cpu_stall) begin
        if (instrQ.size() == 0) begin
          nChecks++;
          $display("FAIL unexpected_hit: got 0x%0h at addr 0x%0h, expected no delivery", cpu_instr, cpu_addr);
        end else check("cpu_instr", cpu_instr, instrQ.pop_front());
      end
      if (!reset && mem_req && mem_ack) begin
        if (addrQ.size() == 0) begin
          nChecks++;
          $display("FAIL unexpected_mem_read: got 0x%0h, expected no request", mem_addr);
        end else check("mem_addr", mem_addr, addrQ.pop_front());
      end
    end
  end

  task automatic doReset();
    reset    = 1'b1;
    cpu_req  = 1'b0;
    inv      = 1'b0;
    cpu_addr = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Issue one fetch and hold it until delivered. Queues the expected word and
  // the expected burst addresses, counts stall cycles, optionally pulses inv
  // after invAt stall cycles (0 = in the first cycle) and wobbles cpu_addr
  // while the fill is in progress.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] expInstr, input int expStall,
                       input int bursts, input int invAt, input bit wobble, input string name);
    int stalls;
    for (int b = 0; b < bursts; b++)
      for (int w = 0; w < 4; w++) addrQ.push_back((addr & 32'hFFFF_FFF0) + 32'(4 * w));
    instrQ.push_back(expInstr);
    cpu_addr = addr;
    cpu_req  = 1'b1;
    inv      = (invAt == 0);
    stalls   = 0;
    forever begin
      @(negedge clk);
      if (!cpu_stall) break;
      stalls++;
      if (stalls > 200) break;
      #1;
      inv = (stalls == invAt);
      if (wobble && stalls >= 2 && stalls < 12) cpu_addr = ((stalls % 2) == 1) ? 32'h8C0 : 32'h44;
      else cpu_addr = addr;
    end
    inv = 1'b0;
    check({name, "_stall_cycles"}, 32'(stalls), 32'(expStall));
    @(posedge clk);
    #1 cpu_req = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    int acks;

    // Reset state, including a fetch request held during reset.
    reset    = 1'b1;
    inv      = 1'b0;
    cpu_req  = 1'b1;
    cpu_addr = 32'h40;
    #12;
    check("rst_stall_follows_req", {31'b0, cpu_stall}, 32'h1);
    check("rst_instr",             cpu_instr, 32'h0);
    check("rst_mem_req",           {31'b0, mem_req}, 32'h0);
    check("rst_mem_addr",          mem_addr, 32'h0);
    check("rst_hit_cnt",           {16'b0, hit_cnt}, 32'h0);
    check("rst_miss_cnt",          {16'b0, miss_cnt}, 32'h0);
    cpu_req = 1'b0;
    #1 check("rst_stall_no_req", {31'b0, cpu_stall}, 32'h0);
    doReset();
    check("idle_stall_no_req", {31'b0, cpu_stall}, 32'h0);

    // Cold miss, then spatial hits on the same line.
    fetch(32'h40, 32'hA0, 6, 1, -1, 1'b0, "cold_miss");
    check("cold_miss_cnt", {16'b0, miss_cnt}, 32'd1);
    fetch(32'h44, 32'hA1, 0, 0, -1, 1'b0, "hit_44");
    fetch(32'h48, 32'hA2, 0, 0, -1, 1'b0, "hit_48");
    fetch(32'h4C, 32'hA3, 0, 0, -1, 1'b0, "hit_4c");
    check("spatial_hit_cnt",  {16'b0, hit_cnt},  32'd4);
    check("spatial_miss_cnt", {16'b0, miss_cnt}, 32'd1);

    // Conflict eviction on index 4.
    doReset();
    fetch(32'h040, 32'hA0,  6, 1, -1, 1'b0, "conflict_a");
    fetch(32'h440, 32'h1A0, 6, 1, -1, 1'b0, "conflict_b");
    fetch(32'h040, 32'hA0,  6, 1, -1, 1'b0, "conflict_c");
    check("conflict_miss_cnt", {16'b0, miss_cnt}, 32'd3);
    check("conflict_hit_cnt",  {16'b0, hit_cnt},  32'd3);

    // Slow memory with the fetch address wobbling during the fill.
    memDelay = 3;
    fetch(32'h80, 32'hB0, 18, 1, -1, 1'b1, "slow_wobble");
    memDelay = 0;
    fetch(32'h40, 32'hA0, 0, 0, -1, 1'b0, "still_valid_40");

    // Invalidate while idle: both lines must miss again.
    @(posedge clk);
    #1 inv = 1'b1;
    @(posedge clk);
    #1 inv = 1'b0;
    fetch(32'h40, 32'hA0, 6, 1, -1, 1'b0, "after_inv_40");
    fetch(32'h80, 32'hB0, 6, 1, -1, 1'b0, "after_inv_80");
    // Invalidate in the same cycle a miss starts: the miss proceeds.
    fetch(32'hC0, 32'hC0, 6, 1, 0, 1'b0, "inv_with_miss");
    // Invalidate mid-fill: the line is not kept, so it misses straight again.
    fetch(32'h140, 32'hE0, 12, 2, 3, 1'b0, "inv_mid_fill");
    fetch(32'hC0, 32'hC0, 6, 1, -1, 1'b0, "after_midfill_inv_c0");
    check("inv_miss_cnt", {16'b0, miss_cnt}, 32'd10);
    check("inv_hit_cnt",  {16'b0, hit_cnt},  32'd10);

    // Reset after the second ack of a fill.
    cpu_addr = 32'h200;
    cpu_req  = 1'b1;
    addrQ.push_back(32'h200);
    addrQ.push_back(32'h204);
    acks = 0;
    for (int i = 0; i < 50 && acks < 2; i++) begin
      @(negedge clk);
      if (mem_req && mem_ack) acks++;
    end
    check("acks_before_reset", 32'(acks), 32'd2);
    #1 reset = 1'b1;
    #1;
    check("midfill_rst_mem_req",  {31'b0, mem_req}, 32'h0);
    check("midfill_rst_mem_addr", mem_addr, 32'h0);
    check("midfill_rst_hit_cnt",  {16'b0, hit_cnt}, 32'h0);
    check("midfill_rst_miss_cnt", {16'b0, miss_cnt}, 32'h0);
    check("midfill_rst_stall",    {31'b0, cpu_stall}, 32'h1);
    check("midfill_rst_instr",    cpu_instr, 32'h0);
    @(posedge clk);
    @(negedge clk);
    #1;
    reset   = 1'b0;
    cpu_req = 1'b0;
    @(posedge clk);
    #1;
    fetch(32'h200, 32'h110, 6, 1, -1, 1'b0, "after_midfill_reset");
    check("after_reset_miss_cnt", {16'b0, miss_cnt}, 32'd1);

    repeat (3) @(posedge clk);
    check("instr_queue_drained", 32'(instrQ.size()), 32'd0);
    check("addr_queue_drained",  32'(addrQ.size()),  32'd0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
